// File: rtl/hash_drbg_pkg.sv
// Shared types and defaults for the hash_drbg arbiter: FSM state encoding,
// default generator width, reseed interval and watchdog limit.
package hash_drbg_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT        = 2'd1,
    RESEED_WAIT = 2'd2
  } state_t;

  localparam int DEF_DATA_WIDTH      = 256;
  localparam int DEF_RESEED_INTERVAL = 1024;
  localparam int DEF_TIMEOUT_CYCLES  = 4096;

  // Bits needed to hold every value in 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hash_drbg_rr_picker.sv
// Combinational round-robin picker: first pending bit searching upward from
// last_grant+1 with wrap-around.
module hash_drbg_rr_picker #(
  parameter int N_REQ = 2,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             any_valid
);

  always_comb begin
    int idx;
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    // Offset 1..N_REQ makes last_grant the lowest-priority candidate.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!any_valid && pending[IW'(idx)]) begin
        grant     = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hash_drbg_arbiter.sv
// Shares one hash_drbg generator among N_REQ consumers with round-robin grants
// and periodic reseeds. Define HASH_DRBG_ARB_TIMEOUT_EN to add the WAIT watchdog.
module hash_drbg_arbiter
  import hash_drbg_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int RESEED_INTERVAL = DEF_RESEED_INTERVAL,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic                     gen_busy,
  input  logic [DATA_WIDTH-1:0]    gen_data,
  input  logic                     gen_data_valid,
  output logic                     gen_next,
  output logic                     gen_reseed,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [N_REQ-1:0]         out_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = cnt_width(RESEED_INTERVAL);
  localparam logic [CW-1:0] CNT_MAX = CW'(RESEED_INTERVAL);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("hash_drbg_arbiter: unsupported parameter set");
  end

  state_t           state;
  logic [N_REQ-1:0] pending;
  logic [IW-1:0]    last_grant;
  logic [CW-1:0]    gen_count;
  logic             rs_first;

  logic [IW-1:0]    pick;
  logic             pick_vld;
  logic             reseed_due;
  logic             deliver;
  logic             timed_out;
  logic [N_REQ-1:0] clear;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  hash_drbg_rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_grant),
    .grant      (pick),
    .any_valid  (pick_vld)
  );

  assign reseed_due = (RESEED_INTERVAL != 0) && (gen_count == CNT_MAX);
  // A valid coincident with our own gen_next pulse belongs to nothing we asked for.
  assign deliver    = (state == WAIT) && gen_data_valid && !gen_next;
  assign clear      = deliver ? onehot(grant_id) : '0;
  assign busy       = (state != IDLE);

`ifdef HASH_DRBG_ARB_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  logic [TW-1:0] wait_cnt;
  assign timed_out = (state == WAIT) && !deliver && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pending     <= '0;
      last_grant  <= IW'(N_REQ - 1);
      grant_id    <= '0;
      gen_count   <= '0;
      rs_first    <= 1'b0;
      gen_next    <= 1'b0;
      gen_reseed  <= 1'b0;
      out_valid   <= '0;
      out_data    <= '0;
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      gen_next   <= 1'b0;
      gen_reseed <= 1'b0;
      out_valid  <= '0;
      // A fresh req on the bit being cleared wins over the clear.
      pending    <= (pending & ~clear) | req;

      case (state)
        IDLE: begin
          if (reseed_due && !gen_busy) begin
            gen_reseed <= 1'b1;
            rs_first   <= 1'b1;
            state      <= RESEED_WAIT;
          end else if (pick_vld && !gen_busy) begin
            grant_id   <= pick;
            last_grant <= pick;
            gen_next   <= 1'b1;
            state      <= WAIT;
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end

        WAIT: begin
          if (deliver) begin
            out_data  <= gen_data;
            out_valid <= clear;
            gen_count <= sat_inc(gen_count);
            state     <= IDLE;
          end else if (timed_out) begin
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
            timeout_err <= 1'b1;
`endif
            state       <= IDLE;
          end
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESEED_WAIT: begin
          // First cycle is unconditional so the generator can raise gen_busy.
          if (rs_first) begin
            rs_first <= 1'b0;
          end else if (!gen_busy) begin
            gen_count <= '0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_drbg_arbiter.sv
// Directed bench for hash_drbg_arbiter (N_REQ=2, RESEED_INTERVAL=3, TIMEOUT_CYCLES=16);
// the watchdog section runs only when HASH_DRBG_ARB_TIMEOUT_EN is defined.
module tb_hash_drbg_arbiter;

  localparam int N  = 2;
  localparam int DW = 256;
  localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] PAT_5A = {32{8'h5A}};
  localparam logic [DW-1:0] PAT_FF = {32{8'hFF}};

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req;
  logic          gen_busy;
  logic [DW-1:0] gen_data;
  logic          gen_data_valid;
  logic          gen_next;
  logic          gen_reseed;
  logic [DW-1:0] out_data;
  logic [N-1:0]  out_valid;
  logic [0:0]    grant_id;
  logic          busy;
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hash_drbg_arbiter #(
    .N_REQ           (N),
    .DATA_WIDTH      (DW),
    .RESEED_INTERVAL (3),
    .TIMEOUT_CYCLES  (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .gen_busy       (gen_busy),
    .gen_data       (gen_data),
    .gen_data_valid (gen_data_valid),
    .gen_next       (gen_next),
    .gen_reseed     (gen_reseed),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .grant_id       (grant_id),
    .busy           (busy)
`ifdef HASH_DRBG_ARB_TIMEOUT_EN
    ,
    .timeout_err    (timeout_err)
`endif
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_next(input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      tick;
      if (gen_next) break;
    end
    chk(tag, DW'(gen_next), DW'(1));
  endtask

  task automatic deliver(input logic [DW-1:0] d, input int pre, input logic [N-1:0] extra);
    logic [N-1:0] keep;
    keep = req;
    repeat (pre) tick;
    gen_data       = d;
    gen_data_valid = 1'b1;
    req            = keep | extra;
    tick;
    gen_data_valid = 1'b0;
    req            = keep;
  endtask

  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick;
      seen = seen | gen_next;
    end
    chk(tag, DW'(seen), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    logic          seen;
    logic          seen_busy;

    reset = 1'b1; req = '0; gen_busy = 1'b0; gen_data = '0; gen_data_valid = 1'b0;
    repeat (3) tick;
    chk("rst_gen_next", DW'(gen_next), DW'(0));
    chk("rst_gen_reseed", DW'(gen_reseed), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_grant_id", DW'(grant_id), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    reset = 1'b0;

    // Single request, data three cycles after gen_next.
    req = 2'b01;
    tick;
    req = 2'b00;
    tick;
    chk("single_next", DW'(gen_next), DW'(1));
    chk("single_grant", DW'(grant_id), DW'(0));
    chk("single_busy", DW'(busy), DW'(1));
    tick;
    chk("single_next_pulse", DW'(gen_next), DW'(0));
    deliver(PAT_A5, 2, 2'b00);
    chk("single_out_valid", DW'(out_valid), DW'(2'b01));
    chk("single_out_data", out_data, PAT_A5);
    chk("single_idle", DW'(busy), DW'(0));
    tick;
    chk("single_valid_pulse", DW'(out_valid), DW'(0));
    quiet("single_no_regrant", 6);

    // Round-robin with both requests held, reseed after every third delivery.
    do_reset;
    req = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_next("rr_next", 10);
      chk("rr_grant", DW'(grant_id), DW'(i % 2));
      d = {8{32'hC0DE_0000 + 32'(i)}};
      deliver(d, 2, 2'b00);
      chk("rr_out_valid", DW'(out_valid), (i % 2 == 0) ? DW'(2'b01) : DW'(2'b10));
      chk("rr_out_data", out_data, d);
      if (i == 2 || i == 5) begin
        tick;
        chk("rr_reseed", DW'(gen_reseed), DW'(1));
        chk("rr_reseed_no_next", DW'(gen_next), DW'(0));
        gen_busy = 1'b1;
        seen = 1'b0;
        repeat (4) begin
          tick;
          seen = seen | gen_next | gen_reseed;
        end
        chk("rr_reseed_hold", DW'(seen), DW'(0));
        chk("rr_reseed_busy", DW'(busy), DW'(1));
        gen_busy = 1'b0;
      end
    end
    req = 2'b00;

    // Request on the same edge that delivers consumer 1 keeps it pending.
    do_reset;
    req = 2'b10;
    tick;
    req = 2'b00;
    wait_next("se_next1", 6);
    chk("se_grant1", DW'(grant_id), DW'(1));
    deliver(PAT_5A, 2, 2'b10);
    chk("se_out_valid1", DW'(out_valid), DW'(2'b10));
    tick;
    chk("se_regrant", DW'(gen_next), DW'(1));
    chk("se_grant2", DW'(grant_id), DW'(1));
    deliver(PAT_A5, 3, 2'b00);
    chk("se_out_valid2", DW'(out_valid), DW'(2'b10));
    quiet("se_cleared", 6);

    // Generator busy stalls issue; pending requests survive.
    gen_busy = 1'b1;
    req = 2'b11;
    tick;
    req = 2'b00;
    seen = 1'b0;
    seen_busy = 1'b0;
    repeat (20) begin
      tick;
      seen = seen | gen_next;
      seen_busy = seen_busy | busy;
    end
    chk("stall_no_next", DW'(seen), DW'(0));
    chk("stall_idle", DW'(seen_busy), DW'(0));
    gen_busy = 1'b0;
    wait_next("stall_release", 4);
    chk("stall_grant", DW'(grant_id), DW'(0));
    chk("stall_wait_busy", DW'(busy), DW'(1));

    // Asynchronous reset while in WAIT, followed by a stale data valid.
    reset = 1'b1;
    #1;
    chk("midrst_gen_next", DW'(gen_next), DW'(0));
    chk("midrst_busy", DW'(busy), DW'(0));
    chk("midrst_grant", DW'(grant_id), DW'(0));
    chk("midrst_out_data", out_data, DW'(0));
    tick;
    reset = 1'b0;
    gen_data = PAT_FF;
    gen_data_valid = 1'b1;
    tick;
    gen_data_valid = 1'b0;
    chk("late_valid_ignored", DW'(out_valid), DW'(0));
    chk("late_data_ignored", out_data, DW'(0));
    quiet("post_rst_no_next", 6);

`ifdef HASH_DRBG_ARB_TIMEOUT_EN
    // Withheld data: watchdog fires after 16 WAIT cycles and the request retries.
    req = 2'b01;
    tick;
    req = 2'b00;
    wait_next("to_next", 6);
    chk("to_err_clear", DW'(timeout_err), DW'(0));
    repeat (15) tick;
    chk("to_err_early", DW'(timeout_err), DW'(0));
    chk("to_still_wait", DW'(busy), DW'(1));
    tick;
    chk("to_err_set", DW'(timeout_err), DW'(1));
    chk("to_idle", DW'(busy), DW'(0));
    tick;
    chk("to_retry_next", DW'(gen_next), DW'(1));
    chk("to_retry_grant", DW'(grant_id), DW'(0));
    deliver(PAT_A5, 2, 2'b00);
    chk("to_retry_valid", DW'(out_valid), DW'(2'b01));
    chk("to_err_sticky", DW'(timeout_err), DW'(1));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
